// File: rtl/loopback_stream_sched.sv
// loopback_stream_sched
//   Sequencer for the loopback read -> FIFO -> write datapath. An accepted
//   start splits a transfer of total_lines cache lines into read bursts of at
//   most BURST_LINES lines. A credit counter, one credit per FIFO line, makes
//   sure no more lines are requested than the FIFO can hold. Write completions
//   are counted, and finish is raised once every line has been written back.
//
//   Optional feature: define LOOPBACK_SCHED_PERF_EN to add the perf_cycles and
//   perf_stall counters. Without it those ports and counters do not exist.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   start, total_lines  start pulse; line count sampled when start is accepted
//   rd_req_*            read request channel (valid/ready, offset, len)
//   fifo_deq            one line left the FIFO, which returns one credit
//   wr_done             one write completion
//   busy, finish, err   status: transfer running / transfer done / sticky error
//   perf_cycles/stall   (LOOPBACK_SCHED_PERF_EN only) busy and stalled cycles
module loopback_stream_sched #(
  parameter int LINE_CNT_W  = 32,
  parameter int BURST_LINES = 8,
  parameter int MAX_CREDITS = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LINE_CNT_W-1:0] total_lines,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [LINE_CNT_W-1:0] rd_req_offset,
  output logic [LINE_CNT_W-1:0] rd_req_len,
  input  logic                  fifo_deq,
  input  logic                  wr_done,
  output logic                  busy,
  output logic                  finish,
  output logic                  err
`ifdef LOOPBACK_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall
`endif
);

  localparam int CRED_W = $clog2(MAX_CREDITS + 1);
  localparam logic [CRED_W-1:0]     CRED_MAX = CRED_W'(MAX_CREDITS);
  localparam logic [LINE_CNT_W-1:0] BURST    = LINE_CNT_W'(BURST_LINES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Length of the burst that starts at off: the remaining lines, capped at BURST.
  function automatic logic [LINE_CNT_W-1:0] burst_len(input logic [LINE_CNT_W-1:0] total,
                                                      input logic [LINE_CNT_W-1:0] off);
    logic [LINE_CNT_W-1:0] rem;
    rem = total - off;
    return (rem < BURST) ? rem : BURST;
  endfunction

  state_t                state_q, state_d;
  logic [LINE_CNT_W-1:0] total_q, total_d;
  logic [LINE_CNT_W-1:0] next_off_q, next_off_d;
  logic [LINE_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic                  rd_req_valid_q, rd_req_valid_d;
  logic [LINE_CNT_W-1:0] rd_req_offset_q, rd_req_offset_d;
  logic [LINE_CNT_W-1:0] rd_req_len_q, rd_req_len_d;
  logic                  busy_q, busy_d;
  logic                  finish_q, finish_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic                  start_acc;
  logic [CRED_W-1:0]     cred_after_hs;
  logic [LINE_CNT_W-1:0] nxt_len;

  always_comb begin
    state_d         = state_q;
    total_d         = total_q;
    next_off_d      = next_off_q;
    wr_cnt_d        = wr_cnt_q;
    credits_d       = credits_q;
    rd_req_valid_d  = 1'b0;
    rd_req_offset_d = rd_req_offset_q;
    rd_req_len_d    = rd_req_len_q;
    err_d           = err_q;
    start_acc       = 1'b0;
    nxt_len         = '0;

    hs = rd_req_valid_q && rd_req_ready;
    if (hs) next_off_d = next_off_q + rd_req_len_q;

    // The handshake takes its credits first. A dequeue then returns one credit,
    // unless the count is already full (a dequeue that was never requested).
    cred_after_hs = credits_q - (hs ? CRED_W'(rd_req_len_q) : '0);
    credits_d     = cred_after_hs;
    if (fifo_deq) begin
      if (cred_after_hs == CRED_MAX) err_d = 1'b1;
      else                           credits_d = cred_after_hs + 1'b1;
    end

    if (wr_done) begin
      if (wr_cnt_q == total_q) err_d = 1'b1;
      else                     wr_cnt_d = wr_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: start_acc = start;
      ISSUE:      if (hs && (next_off_d == total_q)) state_d = DRAIN;
      DRAIN:      if (wr_cnt_d == total_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase

    // An accepted start overrides any completion counted in the same cycle.
    if (start_acc) begin
      total_d    = total_lines;
      next_off_d = '0;
      wr_cnt_d   = '0;
      err_d      = 1'b0;
      state_d    = (total_lines == '0) ? DONE : ISSUE;
    end

    // Request for the next cycle. It is computed from the post-update offset
    // and credits so that a new burst can follow an accepted one immediately.
    // A pending request keeps its offset and length until it is accepted.
    if (state_d == ISSUE) begin
      if (rd_req_valid_q && !rd_req_ready) begin
        rd_req_valid_d = 1'b1;
      end else if (next_off_d < total_d) begin
        nxt_len = burst_len(total_d, next_off_d);
        if (LINE_CNT_W'(credits_d) >= nxt_len) begin
          rd_req_valid_d  = 1'b1;
          rd_req_offset_d = next_off_d;
          rd_req_len_d    = nxt_len;
        end
      end
    end

    busy_d   = (state_d == ISSUE) || (state_d == DRAIN);
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      total_q         <= '0;
      next_off_q      <= '0;
      wr_cnt_q        <= '0;
      credits_q       <= CRED_MAX;
      rd_req_valid_q  <= 1'b0;
      rd_req_offset_q <= '0;
      rd_req_len_q    <= '0;
      busy_q          <= 1'b0;
      finish_q        <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      total_q         <= total_d;
      next_off_q      <= next_off_d;
      wr_cnt_q        <= wr_cnt_d;
      credits_q       <= credits_d;
      rd_req_valid_q  <= rd_req_valid_d;
      rd_req_offset_q <= rd_req_offset_d;
      rd_req_len_q    <= rd_req_len_d;
      busy_q          <= busy_d;
      finish_q        <= finish_d;
      err_q           <= err_d;
    end
  end

  assign rd_req_valid  = rd_req_valid_q;
  assign rd_req_offset = rd_req_offset_q;
  assign rd_req_len    = rd_req_len_q;
  assign busy          = busy_q;
  assign finish        = finish_q;
  assign err           = err_q;

`ifdef LOOPBACK_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_now;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    // A stall is either a pending request that is not accepted, or no request
    // because the credits do not cover the next burst.
    stall_now = (state_q == ISSUE) &&
                ((rd_req_valid_q && !rd_req_ready) ||
                 (!rd_req_valid_q && (next_off_q < total_q) &&
                  (LINE_CNT_W'(credits_q) < burst_len(total_q, next_off_q))));
    if (start_acc) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if ((state_q == ISSUE) || (state_q == DRAIN)) perf_cycles_d = sat_inc(perf_cycles_q);
      if (stall_now) perf_stall_d = sat_inc(perf_stall_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_loopback_stream_sched.sv
// Testbench for loopback_stream_sched, built with a small FIFO (16 credits) so
// that credit stalls occur. A driver process plays the read port, the FIFO and
// the write side. A monitor keeps a reference model of the transfer: the burst
// list expected for each start, the credit count and the completion count. It
// compares every accepted request and the status outputs with that model.
module tb_loopback_stream_sched;
  localparam int LW = 32;
  localparam int BL = 8;
  localparam int MC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] total_lines;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [LW-1:0] rd_req_offset;
  logic [LW-1:0] rd_req_len;
  logic          fifo_deq;
  logic          wr_done;
  logic          busy;
  logic          finish;
  logic          err;
`ifdef LOOPBACK_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_stall;
`endif

  loopback_stream_sched #(.LINE_CNT_W(LW), .BURST_LINES(BL), .MAX_CREDITS(MC)) dut (
    .clk(clk), .reset(reset), .start(start), .total_lines(total_lines),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_offset(rd_req_offset), .rd_req_len(rd_req_len),
    .fifo_deq(fifo_deq), .wr_done(wr_done),
    .busy(busy), .finish(finish), .err(err)
`ifdef LOOPBACK_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: read port, FIFO and write side ----------------
  int rdy_pct = 100;
  int deq_pct = 60;
  int wr_pct  = 60;
  int deq_budget = -1;   // -1 means unlimited
  bit extra_wr = 1'b0;
  int fifo_pool = 0;     // lines delivered into the FIFO, not yet dequeued
  int wr_pool = 0;       // lines dequeued, write not yet completed

  initial begin
    rd_req_ready = 1'b0;
    fifo_deq = 1'b0;
    wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fifo_pool = 0; wr_pool = 0;
        rd_req_ready = 1'b0; fifo_deq = 1'b0; wr_done = 1'b0;
      end else begin
        fifo_deq = (fifo_pool > 0) && (deq_budget != 0) && (int'($urandom_range(99)) < deq_pct);
        if (extra_wr) begin
          wr_done = 1'b1;
          extra_wr = 1'b0;
        end else begin
          wr_done = (wr_pool > 0) && (int'($urandom_range(99)) < wr_pct);
          if (wr_done) wr_pool--;
        end
        if (fifo_deq) begin
          fifo_pool--; wr_pool++;
          if (deq_budget > 0) deq_budget--;
        end
        rd_req_ready = (int'($urandom_range(99)) < rdy_pct);
        if (rd_req_valid && rd_req_ready) fifo_pool += int'(rd_req_len);
      end
    end
  end

  // ---------------- monitor with reference model ----------------
  typedef struct { int off; int len; } burst_t;
  burst_t exp_q[$];
  int mcred = MC;
  int mtotal = 0;
  int wr_seen = 0;
  int phase = 0;         // 0 idle, 1 running, 2 done
  bit exp_busy = 0, exp_finish = 0, exp_err = 0;
  bit prev_pend = 0;
  logic [LW-1:0] prev_off, prev_len;

  initial begin
    burst_t b;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        exp_q.delete();
        mcred = MC; mtotal = 0; wr_seen = 0; phase = 0;
        exp_busy = 0; exp_finish = 0; exp_err = 0; prev_pend = 0;
      end else begin
        check("busy", busy, exp_busy);
        check("finish", finish, exp_finish);
        check("err", err, exp_err);
        if (rd_req_valid) begin
          check("req_expected", exp_q.size() != 0, 1);
          check("credit_guard", mcred >= int'(rd_req_len), 1);
        end
        if (prev_pend) begin
          check("hold_valid", rd_req_valid, 1);
          check("hold_off", rd_req_offset, prev_off);
          check("hold_len", rd_req_len, prev_len);
        end
        prev_pend = rd_req_valid && !rd_req_ready;
        prev_off = rd_req_offset;
        prev_len = rd_req_len;

        if (rd_req_valid && rd_req_ready && exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("req_off", rd_req_offset, b.off);
          check("req_len", rd_req_len, b.len);
          mcred -= b.len;
        end
        if (fifo_deq) begin
          if (mcred == MC) exp_err = 1; else mcred++;
        end
        if (wr_done) begin
          if (wr_seen == mtotal) exp_err = 1; else wr_seen++;
        end
        if (start && phase != 1) begin
          mtotal = int'(total_lines);
          wr_seen = 0; exp_err = 0;
          exp_q.delete();
          for (int off = 0; off < mtotal; off += BL) begin
            b.off = off;
            b.len = (mtotal - off < BL) ? mtotal - off : BL;
            exp_q.push_back(b);
          end
          phase = (mtotal == 0) ? 2 : 1;
        end else if (phase == 1 && wr_seen == mtotal) begin
          phase = 2;
        end
        exp_busy = (phase == 1);
        exp_finish = (phase == 2);
      end
    end
  end

  // ---------------- sequences ----------------
  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    total_lines = LW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      #3;
      seen = finish;
    end
    check(name, seen, 1);
    check({name, "_all_bursts"}, exp_q.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    total_lines = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_valid", rd_req_valid, 0);
    check("rst_off", rd_req_offset, 0);
    check("rst_len", rd_req_len, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    // 20 lines with ready always high: bursts (0,8),(8,8),(16,4)
    rdy_pct = 100; deq_pct = 60; wr_pct = 60;
    do_start(20);
    wait_finish("xfer20");

    // zero-length transfer finishes at once without requests
    do_start(0);
    #3;
    check("zero_finish", finish, 1);
    check("zero_valid", rd_req_valid, 0);

    // credit stall: 16 credits, 32 lines, no dequeues
    deq_budget = 0; deq_pct = 100;
    do_start(32);
    repeat (30) @(negedge clk);
    check("stall_after_two", exp_q.size(), 2);
    deq_budget = 4;
    repeat (30) @(negedge clk);
    check("stall_after_4deq", exp_q.size(), 2);
    deq_budget = 4;
    repeat (30) @(negedge clk);
    check("resume_after_8deq", exp_q.size(), 1);
    deq_budget = -1; deq_pct = 60;
    wait_finish("xfer32");

    // read port not ready: request held, then accepted once
    rdy_pct = 0;
    do_start(24);
    repeat (6) @(negedge clk);
    #3;
    check("held_valid", rd_req_valid, 1);
    check("held_first_off", rd_req_offset, 0);
    rdy_pct = 100;
    wait_finish("xfer24");

    // extra write completion after finish
    extra_wr = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("extra_wr_err", err, 1);
    check("extra_wr_finish", finish, 1);

    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      rdy_pct = int'($urandom_range(100, 30));
      deq_pct = int'($urandom_range(90, 20));
      wr_pct  = int'($urandom_range(90, 20));
      do_start(int'($urandom_range(60, 1)));
      wait_finish("xfer_rand");
    end

    // asynchronous reset in the middle of a transfer
    rdy_pct = 30; deq_pct = 60; wr_pct = 60;
    do_start(40);
    for (int i = 0; i < 200 && !rd_req_valid; i++) @(negedge clk);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", rd_req_valid, 0);
    check("arst_off", rd_req_offset, 0);
    check("arst_len", rd_req_len, 0);
    check("arst_busy", busy, 0);
    check("arst_finish", finish, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdy_pct = 100;
    do_start(12);
    wait_finish("xfer_after_reset");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
